inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Packs RV32I instruction fields (opcode, funct3, funct7, rd, rs1, rs2, full-width immediate) into a 32-bit instruction word. It is the inverse of the core's decode stage.
- Used by the debug/test injector to feed instructions into the fetch path.
- Validates field legality and immediate range and alignment.
- Buffers results in a small output FIFO with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, >=2)
- CNT_W, 16, width of encoded/error counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- in_opcode  input  7  RV32I opcode
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type; shift-immediate upper bits)
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  32  signed immediate value, unshifted (U-type: full value with [11:0]=0)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_inst  output  32  encoded instruction at FIFO head
- out_err  output  1  head entry was illegal (out_inst = NOP)
- enc_cnt  output  CNT_W  bundles accepted, saturating
- err_cnt  output  CNT_W  illegal bundles accepted, saturating

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, out_inst=0, out_err=0, enc_cnt=0, err_cnt=0, in_ready=1 after release.
- Accept: when in_valid&&in_ready, encode combinationally and push {err,inst} into FIFO on that edge. out_valid rises the next cycle (latency 1 when empty). Unaccepted inputs are ignored.
- Pop: when out_valid&&out_ready, advance head. out_inst/out_err are registered FIFO outputs, stable while out_valid&&!out_ready.
- in_ready = (count < DEPTH), registered/derived from count only. When full, in_ready=0 even if a pop occurs that cycle (no same-cycle push-through when full).
- Push and pop in the same cycle when not full: count unchanged, order preserved. Pointers wrap modulo DEPTH.
- Format from opcode:
  - 0x33: R
  - 0x13, 0x03, 0x67: I
  - 0x23: S
  - 0x63: B
  - 0x37, 0x17: U
  - 0x6F: J
  - anything else: illegal
- Packing is standard RV32I:
  - I: imm[11:0] → [31:20]
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7]
  - B: imm[12|10:5] → [31:25], imm[4:1|11] → [11:7]
  - U: imm[31:12] → [31:12]
  - J: imm[20|10:1|11|19:12] → [31:12]
  - Fields unused by a format are encoded as 0.
- Shift-immediates (0x13, funct3 001/101): [31:25]=in_funct7, [24:20]=imm[4:0].
- Legality; any failure gives err=1, pushed inst=32'h00000013:
  - R: funct7 is 0x00, or 0x20 only with funct3 000/101.
  - I-arith: imm[31:11] sign-uniform.
  - Shifts: imm[31:5]=0; funct7 is 0x00, or 0x20 only for 101; funct3 001 requires funct7=0x00.
  - Load: funct3 in {000,001,010,100,101}, 12-bit signed imm.
  - JALR: funct3=000, 12-bit signed imm.
  - S: funct3 in {000,001,010}, 12-bit signed imm.
  - B: funct3 not 010/011, imm[31:12] sign-uniform, imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] sign-uniform, imm[0]=0.
- Counters: enc_cnt increments on every accept. err_cnt increments on accepts with err=1. Both saturate at all-ones.
- Reset mid-operation: FIFO contents discarded, counters cleared, no partial output.

Test Plan:
- ADDI x1,x0,5 (op 0x13, f3 0, rd 1, imm 5), out_ready=1 -> out_inst=0x00500093, out_err=0, out_valid one cycle after accept, enc_cnt=1.
- SUB x3,x1,x2 (op 0x33, f7 0x20) then JAL x1,+8 -> 0x402081B3 then 0x008000EF, in order.
- BEQ imm=3 (odd); then ADDI imm=0x800 -> both out_err=1, out_inst=0x00000013, err_cnt=2.
- out_ready=0, three back-to-back bundles -> in_ready=0 after 2 accepted, third held. Release out_ready -> original order, third accepted only after count<DEPTH.
- Steady push+pop with out_ready=1 for 20 bundles -> count constant, no drops, pointers wrap, enc_cnt=20.
- rst_n low mid-stream with 2 entries queued -> out_valid=0 and counters=0 immediately; first post-reset bundle encodes correctly.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into a 32-bit instruction word, checks
// field legality / immediate range, and queues {err,inst} in a small FIFO.
module inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } entry_t;

  entry_t          enc;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  // Sign-uniformity of the immediate's upper bits, i.e. fits in N signed bits
  logic s11, s12, s20;
  assign s11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign s12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign s20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // Format selection, packing and legality; illegal bundles become NOP
  always_comb begin
    logic        legal;
    logic [31:0] raw;
    legal = 1'b0;
    raw   = '0;
    case (in_opcode)
      7'h33: begin
        raw   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal = (in_funct7 == 7'h00) ||
                (in_funct7 == 7'h20 && (in_funct3 == 3'b000 || in_funct3 == 3'b101));
      end
      7'h13: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          // shift-immediate: funct7 occupies the upper immediate bits
          raw   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = (in_imm[31:5] == '0) &&
                  ((in_funct7 == 7'h00) ||
                   (in_funct7 == 7'h20 && in_funct3 == 3'b101));
        end else begin
          raw   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = s11;
        end
      end
      7'h03: begin
        raw   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        legal = s11 && (in_funct3 != 3'b011) && (in_funct3 != 3'b110) &&
                (in_funct3 != 3'b111);
      end
      7'h67: begin
        raw   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        legal = s11 && (in_funct3 == 3'b000);
      end
      7'h23: begin
        raw   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal = s11 && (in_funct3 <= 3'b010);
      end
      7'h63: begin
        raw   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], in_opcode};
        legal = s12 && !in_imm[0] && (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
      end
      7'h37, 7'h17: begin
        raw   = {in_imm[31:12], in_rd, in_opcode};
        legal = (in_imm[11:0] == '0);
      end
      7'h6F: begin
        raw   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal = s20 && !in_imm[0];
      end
      default: begin
        raw   = '0;
        legal = 1'b0;
      end
    endcase
    enc.err  = !legal;
    enc.inst = legal ? raw : NOP;
  end

  // No push-through when full: in_ready depends on count only
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_inst  = mem[rd_ptr].inst;
  assign out_err   = mem[rd_ptr].err;

  // FIFO storage and pointers; entries cleared on reset so the head reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating accept / error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (push) begin
      if (enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
      if (enc.err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
